game_flow_controller: RTL and testbench
=======================================

Name: game_flow_controller

Overview:
- Owns the top-level game sequence: screen state (title / playing / game over), PS2 space-key event handshake, bird vertical physics, score and random-generator reseed.
- Sits between PS2_Interface and game_logic_controller / game_render_controller.
- Replaces the ad-hoc screen/ack logic in the top level with one sequenced block.

Parameters:
- TICK_DIV, 833333, clock cycles per physics frame (60 Hz at 50 MHz).
- GRAVITY, 1, velocity increment per frame (px/frame²).
- FLAP_VEL, -8, signed velocity loaded on flap (px/frame).
- MAX_FALL, 10, maximum downward velocity.
- BIRD_Y_INIT, 216, bird Y on reset and on entering title/play.
- FLOOR_Y, 456, bird Y at which ground is hit.
- DEAD_HOLD, 30, frames in game over before a key is accepted.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- space_state  in  2  PS2 key event: 0 none, 1 press, 2 release
- reset_space_state  out  1  ack to PS2_Interface, clears space_state
- collide  in  1  pipe collision level from game logic
- pass_pipe  in  1  one-cycle pulse when bird clears a pipe
- screen  out  2  0 title, 1 playing, 2 game over
- random_reset  out  1  one-cycle pulse reseeding the random generator
- frame_tick  out  1  one-cycle pulse every TICK_DIV cycles
- bird_y  out  10  bird top Y in pixels, unsigned
- score  out  14  pipes passed, binary, saturating at 9999

Behaviour:
- Reset (async, any time, including mid-frame):
  - screen=0, bird_y=BIRD_Y_INIT, velocity=0, score=0.
  - reset_space_state=0, random_reset=0, frame_tick=0.
  - Tick counter=0, hold counter=0.
- Tick:
  - Counter runs 0..TICK_DIV-1 and wraps.
  - frame_tick=1 for exactly the cycle the counter equals TICK_DIV-1.
  - Runs in all screens.
- Key handshake:
  - If space_state!=0 and reset_space_state==0, the event is accepted and reset_space_state=1 on the next cycle.
  - The following cycle reset_space_state=0 unconditionally, so ack is always a single-cycle pulse with at least one low cycle between acks.
  - Only accepted events with value 1 (press) act. Releases are acked with no effect.
- FSM TITLE (0):
  - bird_y held at BIRD_Y_INIT.
  - On press: go to PLAY next cycle; random_reset=1 for one cycle; score=0, velocity=0, bird_y=BIRD_Y_INIT.
- FSM PLAY (1):
  - Press (flap): velocity=FLAP_VEL.
  - On frame_tick, compute in 12-bit signed: ny = bird_y + velocity, and velocity = min(velocity+GRAVITY, MAX_FALL).
    - If ny<=0: bird_y=0, velocity=0.
    - If ny>=FLOOR_Y: bird_y=FLOOR_Y, go to OVER.
    - Otherwise bird_y=ny.
  - Flap in the same cycle as frame_tick: position uses the old velocity; velocity becomes FLAP_VEL (flap overrides gravity).
  - collide=1 on any cycle: go to OVER next cycle; bird_y frozen.
  - pass_pipe: score+1, saturating at 9999. If collide and pass_pipe arrive together, collision wins and score is unchanged.
- FSM OVER (2):
  - bird_y and score frozen; hold counter cleared on entry.
  - Hold counter increments on each frame_tick and saturates at DEAD_HOLD.
  - Press while hold<DEAD_HOLD: acked, ignored.
  - Press while hold==DEAD_HOLD: go to TITLE; bird_y=BIRD_Y_INIT; score kept until the next PLAY start.
- Screen value 3 is unreachable. If ever present, next cycle goes to TITLE.
- All outputs registered; state changes are visible one cycle after the causing input.

Test Plan:
- (All scenarios use TICK_DIV=4, DEAD_HOLD=2.)
- Reset mid-PLAY with bird_y=300 and score=5 -> same cycle: screen=0, bird_y=216, score=0, reset_space_state=0.
- In TITLE, space_state=1 held -> reset_space_state pulses 1 cycle; screen=1 and random_reset=1 for exactly one cycle. Holding space_state=1 gives acks spaced by at least 1 low cycle, and a second press flaps.
- PLAY from rest, no input, 3 ticks -> bird_y 216, 217, 219, velocity=3. Then a flap -> next tick bird_y=222, following tick 214.
- PLAY falling with velocity clamped at 10 until ny>=456 -> bird_y=456, screen=2. At bird_y=4 with velocity=-8 -> bird_y=0, velocity=0, screen stays 1.
- collide=1 and pass_pipe=1 in the same cycle at score=7 -> screen=2, score=7. At score=9999, pass_pipe -> score=9999.
- In OVER, press after 1 tick -> ack, screen stays 2. Press after 2 ticks -> screen=0, bird_y=216, score unchanged. Release events (space_state=2) -> acked, no state change.

Source files
------------

// File: rtl/game_flow_controller.sv
// game_flow_controller
// Top-level game sequencer. It owns the title / playing / game-over screen
// state, the PS2 space-key acknowledge handshake, the bird's vertical physics,
// the pipe score and the pulse that reseeds the random generator.
// Every output is registered, so a cause becomes visible one cycle later.

module game_flow_controller #(
   parameter int TICK_DIV    = 833333,
   parameter int GRAVITY     = 1,
   parameter int FLAP_VEL    = -8,
   parameter int MAX_FALL    = 10,
   parameter int BIRD_Y_INIT = 216,
   parameter int FLOOR_Y     = 456,
   parameter int DEAD_HOLD   = 30
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  space_state,
   output logic        reset_space_state,
   input  logic        collide,
   input  logic        pass_pipe,
   output logic [1:0]  screen,
   output logic        random_reset,
   output logic        frame_tick,
   output logic [9:0]  bird_y,
   output logic [13:0] score
);

   typedef enum logic [1:0] {
      ST_TITLE = 2'd0,
      ST_PLAY  = 2'd1,
      ST_OVER  = 2'd2,
      ST_BAD   = 2'd3
   } state_t;

   localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int HW = (DEAD_HOLD > 1) ? $clog2(DEAD_HOLD + 1) : 1;

   localparam logic [TW-1:0]     TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [HW-1:0]     HOLD_MAX  = HW'(DEAD_HOLD);
   localparam logic [9:0]        BIRD_INIT = 10'(BIRD_Y_INIT);
   localparam logic [13:0]       SCORE_MAX = 14'd9999;
   localparam logic signed [11:0] GRAV_V   = 12'(GRAVITY);
   localparam logic signed [11:0] FLAP_V   = 12'(FLAP_VEL);
   localparam logic signed [11:0] FALL_V   = 12'(MAX_FALL);
   localparam logic signed [11:0] FLOOR_V  = 12'(FLOOR_Y);

   state_t               r_state;
   logic [TW-1:0]        r_tickCnt;
   logic                 r_frameTick;
   logic                 r_ack;
   logic                 r_randomReset;
   logic [9:0]           r_birdY;
   logic signed [11:0]   r_vel;
   logic [13:0]          r_score;
   logic [HW-1:0]        r_hold;

   state_t               w_stateNext;
   logic [TW-1:0]        w_tickNext;
   logic                 w_accept;
   logic                 w_press;
   logic                 w_randomResetNext;
   logic [9:0]           w_birdYNext;
   logic signed [11:0]   w_velNext;
   logic [13:0]          w_scoreNext;
   logic [HW-1:0]        w_holdNext;
   logic signed [11:0]   w_ny;
   logic signed [11:0]   w_velSum;
   logic signed [11:0]   w_velGrav;

   // A key event is taken only when no ack is outstanding, which forces
   // at least one low cycle between acks; releases are acked but never act.
   assign w_accept   = (space_state != 2'd0) && !r_ack;
   assign w_press    = w_accept && (space_state == 2'd1);

   // Frame counter wraps at TICK_DIV-1; the tick flag is registered from
   // the counter's next value so both line up on the same cycle.
   assign w_tickNext = (r_tickCnt == TICK_LAST) ? '0 : r_tickCnt + 1'b1;

   // Physics arithmetic is done in 12-bit signed so that a rising bird
   // above the top edge shows up as a non-positive candidate position.
   assign w_ny       = $signed({2'b00, r_birdY}) + r_vel;
   assign w_velSum   = r_vel + GRAV_V;
   assign w_velGrav  = (w_velSum > FALL_V) ? FALL_V : w_velSum;

   // Frame tick generator and key acknowledge, free-running in every screen.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_tickCnt   <= '0;
         r_frameTick <= 1'b0;
         r_ack       <= 1'b0;
      end else begin
         r_tickCnt   <= w_tickNext;
         r_frameTick <= (w_tickNext == TICK_LAST);
         r_ack       <= w_accept;
      end
   end

   // Game state register: screen, bird position/velocity, score, hold timer.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state       <= ST_TITLE;
         r_birdY       <= BIRD_INIT;
         r_vel         <= '0;
         r_score       <= '0;
         r_hold        <= '0;
         r_randomReset <= 1'b0;
      end else begin
         r_state       <= w_stateNext;
         r_birdY       <= w_birdYNext;
         r_vel         <= w_velNext;
         r_score       <= w_scoreNext;
         r_hold        <= w_holdNext;
         r_randomReset <= w_randomResetNext;
      end
   end

   // Next-state and datapath decisions; in PLAY a collision beats everything
   // else, and a flap always beats gravity for the new velocity.
   always_comb begin
      w_stateNext       = r_state;
      w_birdYNext       = r_birdY;
      w_velNext         = r_vel;
      w_scoreNext       = r_score;
      w_holdNext        = r_hold;
      w_randomResetNext = 1'b0;
      case (r_state)
         ST_TITLE: begin
            w_birdYNext = BIRD_INIT;
            if (w_press) begin
               w_stateNext       = ST_PLAY;
               w_randomResetNext = 1'b1;
               w_scoreNext       = '0;
               w_velNext         = '0;
            end
         end
         ST_PLAY: begin
            if (collide) begin
               w_stateNext = ST_OVER;
               w_holdNext  = '0;
            end else begin
               if (r_frameTick) begin
                  w_velNext = w_velGrav;
                  if (w_ny <= 12'sd0) begin
                     w_birdYNext = '0;
                     w_velNext   = '0;
                  end else if (w_ny >= FLOOR_V) begin
                     w_birdYNext = FLOOR_V[9:0];
                     w_stateNext = ST_OVER;
                     w_holdNext  = '0;
                  end else begin
                     w_birdYNext = w_ny[9:0];
                  end
               end
               if (w_press) begin
                  w_velNext = FLAP_V;
               end
               if (pass_pipe && (r_score != SCORE_MAX)) begin
                  w_scoreNext = r_score + 14'd1;
               end
            end
         end
         ST_OVER: begin
            if (r_frameTick && (r_hold != HOLD_MAX)) begin
               w_holdNext = r_hold + 1'b1;
            end
            if (w_press && (r_hold == HOLD_MAX)) begin
               w_stateNext = ST_TITLE;
               w_birdYNext = BIRD_INIT;
            end
         end
         default: begin
            w_stateNext = ST_TITLE;
            w_birdYNext = BIRD_INIT;
         end
      endcase
   end

   assign reset_space_state = r_ack;
   assign screen            = r_state;
   assign random_reset      = r_randomReset;
   assign frame_tick        = r_frameTick;
   assign bird_y            = r_birdY;
   assign score             = r_score;

endmodule

// File: tb/tb_game_flow_controller.sv
// tb_game_flow_controller
// Directed bench for game_flow_controller with a short frame period and
// hold time. Expected values are queued before each stimulus step and
// popped when the corresponding output is sampled.

module tb_game_flow_controller;

   logic        clock;
   logic        reset;
   logic [1:0]  space_state;
   logic        reset_space_state;
   logic        collide;
   logic        pass_pipe;
   logic [1:0]  screen;
   logic        random_reset;
   logic        frame_tick;
   logic [9:0]  bird_y;
   logic [13:0] score;

   int    checkCount = 0;
   int    passCount  = 0;
   int    failCount  = 0;
   int    expQ[$];
   string tagQ[$];

   int    modelY;
   int    modelV;
   int    modelNy;
   bit    expOver;
   int    doubleAck;
   int    ackCount;
   logic  prevAck;

   game_flow_controller #(
      .TICK_DIV    (4),
      .GRAVITY     (1),
      .FLAP_VEL    (-8),
      .MAX_FALL    (10),
      .BIRD_Y_INIT (216),
      .FLOOR_Y     (456),
      .DEAD_HOLD   (2)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .space_state       (space_state),
      .reset_space_state (reset_space_state),
      .collide           (collide),
      .pass_pipe         (pass_pipe),
      .screen            (screen),
      .random_reset      (random_reset),
      .frame_tick        (frame_tick),
      .bird_y            (bird_y),
      .score             (score)
   );

   // 100 MHz bench clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Hard stop in case the sequence ever stalls
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus(input logic [1:0] sp, input logic col, input logic pp);
      space_state = sp;
      collide     = col;
      pass_pipe   = pp;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic pushExpected(input string tag, input int value);
      tagQ.push_back(tag);
      expQ.push_back(value);
   endtask

   task automatic checkOutput(input logic [31:0] observed);
      int    exp;
      string tag;
      checkCount++;
      if (expQ.size() == 0) begin
         failCount++;
         $error("[TB] FAIL scoreboard_empty observed=%0d expected=none", observed);
      end else begin
         exp = expQ.pop_front();
         tag = tagQ.pop_front();
         assert (observed === exp) passCount++;
         else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, exp);
         end
      end
   endtask

   // Advance until frame_tick is high (the next edge is a physics frame)
   task automatic waitTick();
      for (int n = 0; n < 12 && frame_tick !== 1'b1; n++) step(1);
      pushExpected("tick_wait", 1);
      checkOutput(frame_tick);
   endtask

   initial begin
      applyStimulus(2'd0, 1'b0, 1'b0);
      reset = 1'b0;

      // reset values
      #2 reset = 1'b1;
      pushExpected("rst_screen", 0);
      pushExpected("rst_bird_y", 216);
      pushExpected("rst_score", 0);
      pushExpected("rst_ack", 0);
      pushExpected("rst_random_reset", 0);
      pushExpected("rst_frame_tick", 0);
      #1;
      checkOutput(screen);
      checkOutput(bird_y);
      checkOutput(score);
      checkOutput(reset_space_state);
      checkOutput(random_reset);
      checkOutput(frame_tick);
      step(2);
      reset = 1'b0;

      // frame tick period of 4 cycles, bird parked in title
      waitTick();
      pushExpected("tick_low_a", 0);
      step(1);
      checkOutput(frame_tick);
      pushExpected("tick_low_b", 0);
      step(2);
      checkOutput(frame_tick);
      pushExpected("tick_period", 1);
      step(1);
      checkOutput(frame_tick);
      pushExpected("title_bird_y", 216);
      checkOutput(bird_y);

      // held press in title: start, rejected cycle, then a flap
      applyStimulus(2'd1, 1'b0, 1'b0);
      pushExpected("start_ack", 1);
      pushExpected("start_screen", 1);
      pushExpected("start_random_reset", 1);
      step(1);
      checkOutput(reset_space_state);
      checkOutput(screen);
      checkOutput(random_reset);
      pushExpected("ack_gap", 0);
      pushExpected("random_reset_pulse", 0);
      step(1);
      checkOutput(reset_space_state);
      checkOutput(random_reset);
      pushExpected("ack_second", 1);
      step(1);
      checkOutput(reset_space_state);
      applyStimulus(2'd0, 1'b0, 1'b0);
      waitTick();
      pushExpected("flap_y_1", 208);
      step(1);
      checkOutput(bird_y);
      waitTick();
      pushExpected("flap_y_2", 201);
      step(1);
      checkOutput(bird_y);

      // score a few pipes then reset asynchronously mid-cycle
      applyStimulus(2'd0, 1'b0, 1'b1);
      pushExpected("score_5", 5);
      step(5);
      applyStimulus(2'd0, 1'b0, 1'b0);
      checkOutput(score);
      #2 reset = 1'b1;
      pushExpected("async_screen", 0);
      pushExpected("async_bird_y", 216);
      pushExpected("async_score", 0);
      pushExpected("async_ack", 0);
      #1;
      checkOutput(screen);
      checkOutput(bird_y);
      checkOutput(score);
      checkOutput(reset_space_state);
      step(1);
      reset = 1'b0;

      // start from rest: three ticks, then a flap on a tick edge
      applyStimulus(2'd1, 1'b0, 1'b0);
      pushExpected("play_screen", 1);
      step(1);
      applyStimulus(2'd0, 1'b0, 1'b0);
      checkOutput(screen);
      waitTick();
      pushExpected("rest_y_1", 216);
      step(1);
      checkOutput(bird_y);
      waitTick();
      pushExpected("rest_y_2", 217);
      step(1);
      checkOutput(bird_y);
      waitTick();
      pushExpected("rest_y_3", 219);
      step(1);
      checkOutput(bird_y);
      waitTick();
      applyStimulus(2'd1, 1'b0, 1'b0);
      pushExpected("tick_flap_y", 222);
      step(1);
      applyStimulus(2'd0, 1'b0, 1'b0);
      checkOutput(bird_y);
      waitTick();
      pushExpected("after_flap_y", 214);
      step(1);
      checkOutput(bird_y);

      // free fall to the floor, scoring three pipes on the way down
      modelY  = 214;
      modelV  = -7;
      expOver = 1'b0;
      for (int i = 0; i < 200 && !expOver; i++) begin
         waitTick();
         modelNy = modelY + modelV;
         modelV  = (modelV + 1 > 10) ? 10 : modelV + 1;
         if (modelNy <= 0) begin
            modelY = 0;
            modelV = 0;
         end else if (modelNy >= 456) begin
            modelY  = 456;
            expOver = 1'b1;
         end else begin
            modelY = modelNy;
         end
         pushExpected("fall_y", modelY);
         step(1);
         checkOutput(bird_y);
         if (i < 3) begin
            applyStimulus(2'd0, 1'b0, 1'b1);
            step(1);
            applyStimulus(2'd0, 1'b0, 1'b0);
         end
      end
      pushExpected("floor_screen", 2);
      checkOutput(screen);
      pushExpected("floor_score", 3);
      checkOutput(score);

      // game over: early press and a release are acked but ignored
      waitTick();
      step(1);
      applyStimulus(2'd1, 1'b0, 1'b0);
      pushExpected("early_press_ack", 1);
      pushExpected("early_press_screen", 2);
      step(1);
      applyStimulus(2'd0, 1'b0, 1'b0);
      checkOutput(reset_space_state);
      checkOutput(screen);
      step(1);
      applyStimulus(2'd2, 1'b0, 1'b0);
      pushExpected("over_release_ack", 1);
      pushExpected("over_release_screen", 2);
      pushExpected("over_bird_frozen", 456);
      step(1);
      applyStimulus(2'd0, 1'b0, 1'b0);
      checkOutput(reset_space_state);
      checkOutput(screen);
      checkOutput(bird_y);
      applyStimulus(2'd0, 1'b0, 1'b1);
      pushExpected("over_score_frozen", 3);
      step(1);
      applyStimulus(2'd0, 1'b0, 1'b0);
      checkOutput(score);

      // press once the hold has expired: back to title, score kept
      waitTick();
      step(1);
      applyStimulus(2'd1, 1'b0, 1'b0);
      pushExpected("late_press_screen", 0);
      pushExpected("late_press_bird_y", 216);
      pushExpected("late_press_score", 3);
      step(1);
      applyStimulus(2'd0, 1'b0, 1'b0);
      checkOutput(screen);
      checkOutput(bird_y);
      checkOutput(score);
      step(1);
      applyStimulus(2'd2, 1'b0, 1'b0);
      pushExpected("title_release_ack", 1);
      pushExpected("title_release_screen", 0);
      step(1);
      applyStimulus(2'd0, 1'b0, 1'b0);
      checkOutput(reset_space_state);
      checkOutput(screen);
      step(1);

      // new game, seven pipes, then collide and pass together
      applyStimulus(2'd1, 1'b0, 1'b0);
      pushExpected("restart_screen", 1);
      pushExpected("restart_score", 0);
      pushExpected("restart_random_reset", 1);
      step(1);
      applyStimulus(2'd0, 1'b0, 1'b0);
      checkOutput(screen);
      checkOutput(score);
      checkOutput(random_reset);
      applyStimulus(2'd0, 1'b0, 1'b1);
      pushExpected("score_7", 7);
      step(7);
      applyStimulus(2'd0, 1'b0, 1'b0);
      checkOutput(score);
      applyStimulus(2'd0, 1'b1, 1'b1);
      pushExpected("collide_screen", 2);
      pushExpected("collide_score", 7);
      step(1);
      applyStimulus(2'd0, 1'b0, 1'b0);
      checkOutput(screen);
      checkOutput(score);
      pushExpected("collide_stays_over", 2);
      step(2);
      checkOutput(screen);

      // back through title into play, then hold flap and pass for a long run
      waitTick();
      step(1);
      waitTick();
      step(1);
      applyStimulus(2'd1, 1'b0, 1'b0);
      pushExpected("sat_title", 0);
      step(1);
      applyStimulus(2'd0, 1'b0, 1'b0);
      checkOutput(screen);
      step(1);
      applyStimulus(2'd1, 1'b0, 1'b0);
      pushExpected("sat_play", 1);
      step(1);
      applyStimulus(2'd0, 1'b0, 1'b0);
      checkOutput(screen);

      doubleAck = 0;
      ackCount  = 0;
      prevAck   = 1'b0;
      applyStimulus(2'd1, 1'b0, 1'b1);
      for (int i = 0; i < 10005; i++) begin
         step(1);
         if (prevAck && reset_space_state) doubleAck++;
         if (reset_space_state) ackCount++;
         prevAck = reset_space_state;
      end
      applyStimulus(2'd0, 1'b0, 1'b0);
      pushExpected("score_saturated", 9999);
      checkOutput(score);
      pushExpected("ceiling_screen", 1);
      checkOutput(screen);
      pushExpected("ceiling_bird_y", 0);
      checkOutput(bird_y);
      pushExpected("ack_spacing", 0);
      checkOutput(doubleAck);
      pushExpected("held_acks_seen", 1);
      checkOutput(ackCount > 5000);
      pushExpected("sat_score_hold", 9999);
      applyStimulus(2'd0, 1'b0, 1'b1);
      step(1);
      applyStimulus(2'd0, 1'b0, 1'b0);
      checkOutput(score);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
